// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module : imem_loader_pkg
// Brief  : Loader state encodings and stream-format constants for imem_loader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    localparam logic [2:0] LDR_IDLE = 3'd0;
    localparam logic [2:0] LDR_LEN  = 3'd1;
    localparam logic [2:0] LDR_LOAD = 3'd2;
    localparam logic [2:0] LDR_CSUM = 3'd3;
    localparam logic [2:0] LDR_DONE = 3'd4;
    localparam logic [2:0] LDR_ERR  = 3'd5;

    localparam int LDR_LEN_BYTES = 4;

    function automatic logic ldr_is_busy(input logic [2:0] s);
        return (s == LDR_LEN) || (s == LDR_LOAD) || (s == LDR_CSUM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_csum.sv
// ============================================================================
// Module : imem_loader_csum
// Brief  : Running XOR of accepted payload bytes, cleared at the start of a load.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader_csum
    import imem_loader_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    output logic [7:0] acc_o
);

    logic [7:0] acc_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            acc_q <= 8'h00;
        end else if (clear_i) begin
            acc_q <= 8'h00;
        end else if (en_i) begin
            acc_q <= acc_q ^ data_i;
        end
    end

    assign acc_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module : imem_loader
// Brief  : Streams a length-prefixed program image into byte-wide imem and
//          holds the CPU until the image is complete.
//          Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int MEM_BYTES  = 1024
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [7:0]            byte_in_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [7:0]            mem_wdata_o,
    output logic                  cpu_hold_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [ADDR_WIDTH-2:0] word_count_o
);

    localparam int                  MAX_WORDS   = MEM_BYTES / 4;
    localparam logic [31:0]         MAX_WORDS_C = 32'(MAX_WORDS);
    localparam logic [ADDR_WIDTH-2:0] WC_MAX    = (ADDR_WIDTH-1)'(MAX_WORDS);

    logic [2:0]            state_q,   state_d;
    logic [23:0]           len_sr_q,  len_sr_d;
    logic [1:0]            len_cnt_q, len_cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q,     idx_d;
    logic [ADDR_WIDTH-1:0] last_q,    last_d;
    logic [ADDR_WIDTH-2:0] wc_q,      wc_d;
    logic                  we_q,      we_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [7:0]            wdata_q,   wdata_d;
    logic                  hold_q,    hold_d;

    logic        w_ready;
    logic        w_xfer;
    logic        w_start;
    logic [31:0] w_len;

    assign w_ready = ldr_is_busy(state_q);
    assign w_xfer  = byte_valid_i && w_ready;
    assign w_start = start_i && ((state_q == LDR_IDLE) || (state_q == LDR_DONE) ||
                                 (state_q == LDR_ERR));
    assign w_len   = {len_sr_q, byte_in_i};

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] w_csum_acc;

    imem_loader_csum u_csum (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (w_start),
        .en_i    (w_xfer && (state_q == LDR_LOAD)),
        .data_i  (byte_in_i),
        .acc_o   (w_csum_acc)
    );
`endif

    always_comb begin
        state_d   = state_q;
        len_sr_d  = len_sr_q;
        len_cnt_d = len_cnt_q;
        idx_d     = idx_q;
        last_d    = last_q;
        wc_d      = wc_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;

        case (state_q)
            LDR_IDLE, LDR_DONE, LDR_ERR: begin
                if (w_start) begin
                    state_d   = LDR_LEN;
                    len_cnt_d = 2'd0;
                    idx_d     = '0;
                    wc_d      = '0;
                end
            end
            LDR_LEN: begin
                if (w_xfer) begin
                    len_sr_d  = {len_sr_q[15:0], byte_in_i};
                    len_cnt_d = len_cnt_q + 2'd1;
                    if (len_cnt_q == 2'(LDR_LEN_BYTES - 1)) begin
                        // Oversized images are rejected before any byte touches imem.
                        if (w_len == 32'd0) begin
                            state_d = LDR_DONE;
                        end else if (w_len > MAX_WORDS_C) begin
                            state_d = LDR_ERR;
                        end else begin
                            state_d = LDR_LOAD;
                            last_d  = ADDR_WIDTH'({w_len, 2'b00} - 34'd1);
                        end
                    end
                end
            end
            LDR_LOAD: begin
                if (w_xfer) begin
                    we_d    = 1'b1;
                    addr_d  = idx_q;
                    wdata_d = byte_in_i;
                    idx_d   = idx_q + ADDR_WIDTH'(1);
                    if ((idx_q[1:0] == 2'b11) && (wc_q < WC_MAX)) begin
                        wc_d = wc_q + (ADDR_WIDTH-1)'(1);
                    end
                    if (idx_q == last_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = LDR_CSUM;
`else
                        state_d = LDR_DONE;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            LDR_CSUM: begin
                if (w_xfer) begin
                    state_d = (byte_in_i == w_csum_acc) ? LDR_DONE : LDR_ERR;
                end
            end
`endif
            default: state_d = LDR_IDLE;
        endcase

        // Release lags entry into DONE by one edge so the last write lands first.
        hold_d = !((state_q == LDR_DONE) && (state_d == LDR_DONE));
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= LDR_IDLE;
            len_sr_q  <= 24'd0;
            len_cnt_q <= 2'd0;
            idx_q     <= '0;
            last_q    <= '0;
            wc_q      <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 8'h00;
            hold_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            len_sr_q  <= len_sr_d;
            len_cnt_q <= len_cnt_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            wc_q      <= wc_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            hold_q    <= hold_d;
        end
    end

    assign byte_ready_o = w_ready;
    assign busy_o       = w_ready;
    assign done_o       = (state_q == LDR_DONE);
    assign error_o      = (state_q == LDR_ERR);
    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign cpu_hold_o   = hold_q;
    assign word_count_o = wc_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module : tb_imem_loader
// Brief  : Directed and randomized load streams checked against an image model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int AW = 10;
    localparam int MB = 1024;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic [7:0]    byte_in_i;
    logic          byte_valid_i;
    logic          byte_ready_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [7:0]    mem_wdata_o;
    logic          cpu_hold_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;
    logic [AW-2:0] word_count_o;

    int vectors    = 0;
    int miscompares = 0;

    logic [AW+7:0] wlog[$];

    imem_loader #(.ADDR_WIDTH(AW), .MEM_BYTES(MB)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .byte_in_i    (byte_in_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .cpu_hold_o   (cpu_hold_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .word_count_o (word_count_o)
    );

    always #5 clk = ~clk;

    // Each strobe is one cycle wide, so sampling mid-cycle logs every write once.
    always @(negedge clk) begin
        if (mem_we_o) wlog.push_back({mem_addr_o, mem_wdata_o});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int gap_for(input int gmode, input int k);
        if (gmode == 1) return k % 2;
        if (gmode == 2) return int'($urandom_range(0, 3));
        return 0;
    endfunction

    function automatic logic [7:0] xor_of(input logic [7:0] pl[$]);
        logic [7:0] x = 8'h00;
        foreach (pl[i]) x ^= pl[i];
        return x;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        byte_valid_i = 1'b0;
        repeat (gap) @(negedge clk);
        byte_in_i    = b;
        byte_valid_i = 1'b1;
        while (!byte_ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready_o) begin
            chk("ready_timeout", 64'd0, 64'd1);
            byte_valid_i = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            byte_valid_i = 1'b0;
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send_len(input logic [31:0] n, input int gmode);
        for (int i = 0; i < 4; i++) send_byte(n[31-8*i -: 8], gap_for(gmode, i));
    endtask

    task automatic send_load(input logic [31:0] n, input logic [7:0] pl[$], input int gmode);
        send_len(n, gmode);
        foreach (pl[k]) send_byte(pl[k], gap_for(gmode, k));
        if (CS && pl.size() > 0) send_byte(xor_of(pl), 0);
    endtask

    // Expected image: payload byte k at address k, in stream order.
    task automatic check_log(input string tag, input logic [7:0] pl[$]);
        chk({tag, "_nwrites"}, 64'(wlog.size()), 64'(pl.size()));
        for (int k = 0; k < pl.size() && k < wlog.size(); k++) begin
            chk({tag, "_addr"}, 64'(wlog[k][AW+7:8]), 64'(k));
            chk({tag, "_data"}, 64'(wlog[k][7:0]),    64'(pl[k]));
        end
    endtask

    initial begin
        logic [7:0] prog[$];
        logic [7:0] pl[$];
        logic [7:0] none[$];
        int n;

        prog = '{8'h02, 8'h32, 8'h80, 8'h20, 8'h01, 8'h09, 8'h40, 8'h24};
        reset_i = 1'b1; start_i = 1'b0; byte_in_i = 8'h00; byte_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;

        // Idle with no start: nothing moves.
        repeat (20) begin
            byte_valid_i = 1'b1;
            byte_in_i    = 8'hA5;
            @(negedge clk);
        end
        byte_valid_i = 1'b0;
        chk("rst_hold",  64'(cpu_hold_o),   64'd1);
        chk("rst_ready", 64'(byte_ready_o), 64'd0);
        chk("rst_busy",  64'(busy_o),       64'd0);
        chk("rst_done",  64'(done_o),       64'd0);
        chk("rst_error", 64'(error_o),      64'd0);
        chk("rst_wc",    64'(word_count_o), 64'd0);
        chk("rst_addr",  64'(mem_addr_o),   64'd0);
        chk("rst_nwr",   64'(wlog.size()),  64'd0);

        // Two-word program, with the hold-release boundary.
        wlog.delete();
        pulse_start();
        chk("t2_busy", 64'(busy_o), 64'd1);
        send_load(32'd2, prog, 0);
        chk("t2_hold_edge", 64'(cpu_hold_o), 64'd1);
        chk("t2_done_edge", 64'(done_o),     64'd1);
        if (!CS) begin
            chk("t2_we_edge",    64'(mem_we_o),    64'd1);
            chk("t2_addr_edge",  64'(mem_addr_o),  64'd7);
            chk("t2_wdata_edge", 64'(mem_wdata_o), 64'h24);
        end
        @(negedge clk);
        chk("t2_hold_rel", 64'(cpu_hold_o),   64'd0);
        chk("t2_we_off",   64'(mem_we_o),     64'd0);
        chk("t2_wc",       64'(word_count_o), 64'd2);
        chk("t2_ready",    64'(byte_ready_o), 64'd0);
        check_log("t2", prog);

        // Oversized length: rejected without writes.
        wlog.delete();
        pulse_start();
        chk("t3_done_clr", 64'(done_o), 64'd0);
        chk("t3_hold",     64'(cpu_hold_o), 64'd1);
        send_len(32'd257, 0);
        repeat (3) @(negedge clk);
        chk("t3_error", 64'(error_o),    64'd1);
        chk("t3_done",  64'(done_o),     64'd0);
        chk("t3_hold2", 64'(cpu_hold_o), 64'd1);
        chk("t3_busy",  64'(busy_o),     64'd0);
        chk("t3_nwr",   64'(wlog.size()), 64'd0);

        // Zero length, started from ERR.
        wlog.delete();
        pulse_start();
        chk("t4_err_clr", 64'(error_o), 64'd0);
        send_len(32'd0, 0);
        chk("t4_done", 64'(done_o), 64'd1);
        @(negedge clk);
        chk("t4_wc",   64'(word_count_o), 64'd0);
        chk("t4_hold", 64'(cpu_hold_o),   64'd0);
        chk("t4_nwr",  64'(wlog.size()),  64'd0);

        // Alternating gaps with stray start pulses mid-load.
        wlog.delete();
        pulse_start();
        send_len(32'd2, 1);
        foreach (prog[k]) begin
            if (k == 3 || k == 6) pulse_start();
            send_byte(prog[k], k % 2);
        end
        if (CS) send_byte(xor_of(prog), 1);
        repeat (2) @(negedge clk);
        chk("t5_done", 64'(done_o),       64'd1);
        chk("t5_wc",   64'(word_count_o), 64'd2);
        check_log("t5", prog);

        // Reset after five payload bytes.
        wlog.delete();
        pulse_start();
        send_len(32'd2, 0);
        for (int k = 0; k < 5; k++) send_byte(prog[k], 0);
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        chk("t5r_hold",  64'(cpu_hold_o),   64'd1);
        chk("t5r_busy",  64'(busy_o),       64'd0);
        chk("t5r_ready", 64'(byte_ready_o), 64'd0);
        chk("t5r_done",  64'(done_o),       64'd0);
        pl = prog[0:4];
        check_log("t5r", pl);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum accept and reject.
        wlog.delete();
        pulse_start();
        send_len(32'd2, 0);
        foreach (prog[k]) send_byte(prog[k], 0);
        send_byte(xor_of(prog), 0);
        @(negedge clk);
        chk("t6_done", 64'(done_o), 64'd1);
        check_log("t6", prog);
        wlog.delete();
        pulse_start();
        send_len(32'd2, 0);
        foreach (prog[k]) send_byte(prog[k], 0);
        send_byte(xor_of(prog) ^ 8'h01, 0);
        @(negedge clk);
        chk("t6_error", 64'(error_o),    64'd1);
        chk("t6_hold",  64'(cpu_hold_o), 64'd1);
        check_log("t6b", prog);
`endif

        // Randomized images with random gaps.
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 12));
            pl.delete();
            for (int k = 0; k < 4 * n; k++) pl.push_back(8'($urandom));
            wlog.delete();
            pulse_start();
            send_load(32'(n), pl, 2);
            repeat (2) @(negedge clk);
            chk("rnd_done", 64'(done_o),       64'd1);
            chk("rnd_hold", 64'(cpu_hold_o),   64'd0);
            chk("rnd_wc",   64'(word_count_o), 64'(n));
            check_log("rnd", pl);
        end

        wlog.delete();
        pulse_start();
        send_len(32'($urandom_range(257, 100000)), 2);
        repeat (2) @(negedge clk);
        chk("rnd_big_err", 64'(error_o),     64'd1);
        chk("rnd_big_nwr", 64'(wlog.size()), 64'd0);

        none.delete();
        wlog.delete();
        pulse_start();
        send_load(32'd0, none, 2);
        repeat (2) @(negedge clk);
        chk("rnd_zero_done", 64'(done_o), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
